fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO among NUM_REQ requesters. It accepts one word per cycle from the winning requester and drives the FIFO write port from registers. It throttles on full/almostfull so the FIFO never overflows, and it checks the FIFO's wr_ack/overflow feedback. It sits between the producer agents and the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin write arbiter sharing one synchronous FIFO write port
//            among NUM_REQ requesters, with full/almostfull throttling and
//            sticky wr_ack / overflow error detection.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [15:0]                   grant_cnt,
    output logic                          throttled,
    output logic                          ovf_err,
    output logic                          ack_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_prev_wr;
    logic                   w_can_issue;
    logic                   w_found;
    logic                   w_xfer;
    logic [PTR_W-1:0]       w_sel;
    logic [PTR_W-1:0]       w_cand;
    logic [FIFO_WIDTH-1:0]  w_sel_data;

    // A write already on the port may take the last free slot, so nothing
    // is issued behind it while almostfull.
    assign w_can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
    assign w_xfer      = w_found && w_can_issue && !rst;
    assign throttled   = (r_state == ST_HOLD);

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (w_xfer) begin
            gnt[w_sel] = 1'b1;
        end
    end

    assign w_sel_data = req_data[int'(w_sel)*FIFO_WIDTH +: FIFO_WIDTH];

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (req != '0) begin
            w_state_nxt = w_can_issue ? ST_ACTIVE : ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        // Tracks the port even through reset so a write in flight at reset
        // is not later reported as a spurious ack.
        r_prev_wr <= fifo_wr_en;
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            owner        <= '0;
            grant_cnt    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            ovf_err      <= 1'b0;
            ack_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            fifo_wr_en <= w_xfer;
            if (r_prev_wr != fifo_wr_ack) begin
                ack_err <= 1'b1;
            end
            if (fifo_overflow) begin
                ovf_err <= 1'b1;
            end
            if (w_xfer) begin
                fifo_data_in <= w_sel_data;
                owner        <= w_sel;
                grant_cnt    <= grant_cnt + 16'd1;
                r_ptr        <= (w_sel == PTR_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Randomized scoreboard bench for fifo_wr_arbiter with a depth-8
//            FIFO environment and a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     gnt;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_full;
    logic             fifo_almostfull;
    logic             fifo_wr_ack = 1'b0;
    logic             fifo_overflow = 1'b0;
    logic [1:0]       owner;
    logic [15:0]      grant_cnt;
    logic             throttled;
    logic             ovf_err;
    logic             ack_err;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .owner           (owner),
        .grant_cnt       (grant_cnt),
        .throttled       (throttled),
        .ovf_err         (ovf_err),
        .ack_err         (ack_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO environment: occupancy counter with ack, overflow and fault hooks
    int   fcount     = 0;
    int   n_acc      = 0;
    logic rd_en      = 1'b0;
    logic ack_drop   = 1'b0;
    logic ovf_inject = 1'b0;
    logic env_wr;
    logic env_rd;

    assign fifo_full       = (fcount == DEPTH);
    assign fifo_almostfull = (fcount == DEPTH - 1);
    assign env_wr          = (fifo_wr_en === 1'b1);
    assign env_rd          = rd_en && (fcount > 0);

    always @(posedge clk) begin
        fifo_wr_ack   <= env_wr && (fcount < DEPTH) && !ack_drop;
        fifo_overflow <= (env_wr && (fcount >= DEPTH)) || ovf_inject;
        fcount        <= fcount + ((env_wr && fcount < DEPTH) ? 1 : 0) - (env_rd ? 1 : 0);
        if (env_wr && fcount < DEPTH) n_acc <= n_acc + 1;
    end

    // Reference model state
    int           m_ptr = 0;
    int           m_owner = 0;
    logic [15:0]  m_cnt = '0;
    logic         m_wr_en = 1'b0;
    logic         m_thr = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_ack = 1'b0;
    logic         m_prev_wr = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    logic [N-1:0] pend = '0;
    logic [W-1:0] dat [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write on the port must match the next queued word
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: data %0h with nothing expected at %0t", fifo_data_in, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (fifo_data_in !== mon_exp) begin
                    failures++;
                    $display("FAIL write_data: got %0h expected %0h at %0t", fifo_data_in, mon_exp, $time);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            failures++;
            mon_exp = exp_q.pop_front();
            $display("FAIL missing_write: got wr_en=%b expected data %0h at %0t", fifo_wr_en, mon_exp, $time);
        end
    end

    task automatic drive();
        req = pend;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
    endtask

    task automatic step();
        logic         can, found, xfer;
        int           win, c, n_ptr, n_owner;
        logic [N-1:0] eg;
        logic [15:0]  n_cnt;
        logic         n_wr, n_thr, n_ovf, n_ack, n_prev;
        @(negedge clk);
        can   = !fifo_full && !(fifo_almostfull && m_wr_en);
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                win   = c;
            end
        end
        xfer = found && can && !rst;
        eg = '0;
        if (xfer) eg[win] = 1'b1;
        chk("gnt",       32'(gnt),       32'(eg));
        chk("owner",     32'(owner),     32'(m_owner));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        chk("throttled", 32'(throttled), 32'(m_thr));
        chk("ovf_err",   32'(ovf_err),   32'(m_ovf));
        chk("ack_err",   32'(ack_err),   32'(m_ack));
        n_prev = m_wr_en;
        if (rst) begin
            n_ptr = 0; n_owner = 0; n_cnt = '0; n_wr = 1'b0;
            n_thr = 1'b0; n_ovf = 1'b0; n_ack = 1'b0;
        end else begin
            n_ovf   = m_ovf || fifo_overflow;
            n_ack   = m_ack || (m_prev_wr != fifo_wr_ack);
            n_thr   = (req != '0) && !can;
            n_wr    = xfer;
            n_ptr   = xfer ? (win + 1) % N : m_ptr;
            n_owner = xfer ? win : m_owner;
            n_cnt   = xfer ? m_cnt + 16'd1 : m_cnt;
        end
        @(posedge clk);
        m_ptr = n_ptr; m_owner = n_owner; m_cnt = n_cnt; m_wr_en = n_wr;
        m_thr = n_thr; m_ovf = n_ovf; m_ack = n_ack; m_prev_wr = n_prev;
        if (xfer) exp_q.push_back(dat[win]);
        #1;
        if (xfer) pend[win] = 1'b0;
    endtask

    task automatic refill(input logic [N-1:0] mask, input int pct);
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pend[i] && int'($urandom % 100) < pct) begin
                pend[i] = 1'b1;
                dat[i]  = W'($urandom);
            end
        end
    endtask

    task automatic run(input int cycles, input logic [N-1:0] mask, input int pct, input int rd_pct);
        repeat (cycles) begin
            refill(mask, pct);
            rd_en = int'($urandom % 100) < rd_pct;
            drive();
            step();
        end
    endtask

    int acc0;

    initial begin
        for (int i = 0; i < N; i++) dat[i] = '0;
        drive();
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b0;

        // Single requester, empty FIFO
        pend[0] = 1'b1;
        dat[0]  = 16'hA5A5;
        drive();
        step();
        drive();
        step();
        chk("first_owner", 32'(owner), 32'd0);
        chk("first_cnt",   32'(grant_cnt), 32'd1);

        // All requesters held: strict rotation
        rd_en = 1'b1;
        run(8, 4'b1111, 100, 100);
        chk("rr_cnt", 32'(grant_cnt), 32'd9);
        run(8, 4'b0000, 0, 100);
        chk("rr_ack_err", 32'(ack_err), 32'd0);

        // Stream one requester into an unread FIFO
        acc0 = n_acc;
        run(20, 4'b0100, 100, 0);
        chk("fill_writes", 32'(n_acc - acc0), 32'd8);
        chk("fill_throttled", 32'(throttled), 32'd1);
        chk("fill_ovf_err", 32'(ovf_err), 32'd0);

        // One read from full frees exactly one slot
        acc0 = n_acc;
        run(1, 4'b0100, 100, 100);
        run(8, 4'b0100, 100, 0);
        chk("one_read_writes", 32'(n_acc - acc0), 32'd1);
        chk("one_read_throttled", 32'(throttled), 32'd1);

        // Randomized traffic with varying request and read pressure
        for (int b = 0; b < 8; b++) begin
            run(50, N'($urandom), 20 + int'($urandom % 80), 30 + int'($urandom % 70));
        end

        // Reset in the middle of streaming
        run(10, 4'b0000, 0, 100);
        run(5, 4'b0110, 100, 100);
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
        chk("rst_cnt", 32'(grant_cnt), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        run(4, 4'b0110, 100, 100);

        // Fault injection: dropped ack, then overflow pulse
        run(10, 4'b0000, 0, 100);
        pend[0] = 1'b1;
        dat[0]  = W'($urandom);
        drive();
        step();
        ack_drop = 1'b1;
        drive();
        step();
        ack_drop = 1'b0;
        run(2, 4'b0000, 0, 100);
        chk("drop_ack_err", 32'(ack_err), 32'd1);
        chk("drop_ovf_err", 32'(ovf_err), 32'd0);
        ovf_inject = 1'b1;
        step();
        ovf_inject = 1'b0;
        run(2, 4'b0000, 0, 100);
        chk("inj_ovf_err", 32'(ovf_err), 32'd1);
        run(3, 4'b0000, 0, 100);
        chk("sticky_ack_err", 32'(ack_err), 32'd1);
        chk("sticky_ovf_err", 32'(ovf_err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("clr_ack_err", 32'(ack_err), 32'd0);
        chk("clr_ovf_err", 32'(ovf_err), 32'd0);
        run(3, 4'b0000, 0, 100);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
